io_bridge_fl: RTL and testbench

Peripheral-side responder for the floating-point processor's I/O port. It answers processor input requests (`req_in`/`addr_in`) with data from per-channel input holding registers filled by external producers. It captures processor output writes (`out_en`/`addr_out`/`io_out`) into per-channel output registers, which it presents to external consumers through valid/ready handshakes. It sits between the processor top and the board-level peripherals and raises sticky error flags on underrun and overflow.

---
 rtl/io_bridge_fl.sv | 120 ++++++++++++
 tb/tb_io_bridge_fl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/io_bridge_fl.sv
// io_bridge_fl
//   Peripheral-side responder for the floating-point processor's I/O port.
//   Input side: per-channel holding registers filled by producers over a
//   valid/ready handshake and drained by processor pops (req_in/addr_in).
//   Output side: per-channel registers written by the processor
//   (out_en/addr_out/io_out) and drained by consumers over valid/ready.
//   Sticky underrun/overflow flags report reads of empty channels and
//   overwrites of unconsumed words.
//
// Ports
//   clk, rst              : clock (rising edge), asynchronous active-high reset
//   io_in                 : read data to the processor (combinational on addr_in)
//   addr_in, req_in       : processor input channel select and pop strobe
//   io_out, addr_out,
//   out_en                : processor write data, channel select, write strobe
//   src_data/valid/ready  : producer side, channel k at [k*NBW +: NBW]
//   snk_data/valid/ready  : consumer side, same packing
//   underrun, overflow    : sticky error flags, one bit per channel
//   clr_flags             : synchronous clear of all sticky flags
module io_bridge_fl #(
  parameter int NBMANT = 16,
  parameter int NBEXPO = 6,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8,
  localparam int NBW   = NBMANT + NBEXPO + 1,
  localparam int AIW   = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
  localparam int AOW   = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [NBW-1:0]        io_in,
  input  logic [AIW-1:0]        addr_in,
  input  logic                  req_in,
  input  logic [NBW-1:0]        io_out,
  input  logic [AOW-1:0]        addr_out,
  input  logic                  out_en,
  input  logic [NUIOIN*NBW-1:0] src_data,
  input  logic [NUIOIN-1:0]     src_valid,
  output logic [NUIOIN-1:0]     src_ready,
  output logic [NUIOOU*NBW-1:0] snk_data,
  output logic [NUIOOU-1:0]     snk_valid,
  input  logic [NUIOOU-1:0]     snk_ready,
  output logic [NUIOIN-1:0]     underrun,
  output logic [NUIOOU-1:0]     overflow,
  input  logic                  clr_flags
);

  logic [NUIOIN*NBW-1:0] in_reg_q,   in_reg_d;
  logic [NUIOIN-1:0]     in_full_q,  in_full_d;
  logic [NUIOIN-1:0]     underrun_q, underrun_d;
  logic [NUIOOU*NBW-1:0] out_reg_q,  out_reg_d;
  logic [NUIOOU-1:0]     snk_vld_q,  snk_vld_d;
  logic [NUIOOU-1:0]     overflow_q, overflow_d;

  // Ready is forced low while reset is held so no handshake completes then.
  assign src_ready = ~in_full_q & {NUIOIN{~rst}};
  assign snk_data  = out_reg_q;
  assign snk_valid = snk_vld_q;
  assign underrun  = underrun_q;
  assign overflow  = overflow_q;

  // Read mux: an address matching no channel leaves io_in at zero.
  always_comb begin
    io_in = '0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (addr_in == AIW'(k)) io_in = in_reg_q[k*NBW +: NBW];
    end
  end

  always_comb begin
    in_reg_d   = in_reg_q;
    in_full_d  = in_full_q;
    underrun_d = clr_flags ? '0 : underrun_q;
    out_reg_d  = out_reg_q;
    snk_vld_d  = snk_vld_q;
    overflow_d = clr_flags ? '0 : overflow_q;

    for (int k = 0; k < NUIOIN; k++) begin
      // Pop first, then load: a load on the same empty channel wins and
      // leaves it full, while the processor still sees the stale word.
      if (req_in && (addr_in == AIW'(k))) begin
        in_full_d[k] = 1'b0;
        if (!in_full_q[k]) underrun_d[k] = 1'b1;
      end
      if (src_valid[k] && !in_full_q[k]) begin
        in_reg_d[k*NBW +: NBW] = src_data[k*NBW +: NBW];
        in_full_d[k]           = 1'b1;
      end
    end

    for (int j = 0; j < NUIOOU; j++) begin
      if (snk_vld_q[j] && snk_ready[j]) snk_vld_d[j] = 1'b0;
      if (out_en && (addr_out == AOW'(j))) begin
        out_reg_d[j*NBW +: NBW] = io_out;
        snk_vld_d[j]            = 1'b1;
        // Only a word nobody is taking this cycle is lost.
        if (snk_vld_q[j] && !snk_ready[j]) overflow_d[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_reg_q   <= '0;
      in_full_q  <= '0;
      underrun_q <= '0;
      out_reg_q  <= '0;
      snk_vld_q  <= '0;
      overflow_q <= '0;
    end else begin
      in_reg_q   <= in_reg_d;
      in_full_q  <= in_full_d;
      underrun_q <= underrun_d;
      out_reg_q  <= out_reg_d;
      snk_vld_q  <= snk_vld_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_io_bridge_fl.sv
module tb_io_bridge_fl;
  localparam int NBW = 23;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Eight-channel instance
  logic [NBW-1:0]   io_in, io_out;
  logic [2:0]       addr_in, addr_out;
  logic             req_in, out_en, clr_flags;
  logic [8*NBW-1:0] src_data, snk_data;
  logic [7:0]       src_valid, src_ready, snk_valid, snk_ready, underrun, overflow;

  // Six-channel instance for out-of-range addresses
  logic [NBW-1:0]   io_in6, io_out6;
  logic [2:0]       addr_in6, addr_out6;
  logic             req_in6, out_en6, clr_flags6;
  logic [6*NBW-1:0] src_data6, snk_data6;
  logic [5:0]       src_valid6, src_ready6, snk_valid6, snk_ready6, underrun6, overflow6;

  int vectors = 0;
  int miscompares = 0;

  io_bridge_fl #(.NBMANT(16), .NBEXPO(6), .NUIOIN(8), .NUIOOU(8)) dut (
    .clk(clk), .rst(rst), .io_in(io_in), .addr_in(addr_in), .req_in(req_in),
    .io_out(io_out), .addr_out(addr_out), .out_en(out_en),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .underrun(underrun), .overflow(overflow), .clr_flags(clr_flags)
  );

  io_bridge_fl #(.NBMANT(16), .NBEXPO(6), .NUIOIN(6), .NUIOOU(6)) dut6 (
    .clk(clk), .rst(rst), .io_in(io_in6), .addr_in(addr_in6), .req_in(req_in6),
    .io_out(io_out6), .addr_out(addr_out6), .out_en(out_en6),
    .src_data(src_data6), .src_valid(src_valid6), .src_ready(src_ready6),
    .snk_data(snk_data6), .snk_valid(snk_valid6), .snk_ready(snk_ready6),
    .underrun(underrun6), .overflow(overflow6), .clr_flags(clr_flags6)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    addr_in = '0; req_in = 0; io_out = '0; addr_out = '0; out_en = 0; clr_flags = 0;
    src_data = '0; src_valid = '0; snk_ready = '0;
    addr_in6 = '0; req_in6 = 0; io_out6 = '0; addr_out6 = '0; out_en6 = 0; clr_flags6 = 0;
    src_data6 = '0; src_valid6 = '0; snk_ready6 = '0;

    tick(); tick();
    #1;
    chk("rst_src_ready", src_ready, 8'h00);
    chk("rst_io_in",     io_in,     0);
    chk("rst_snk_data",  snk_data,  0);
    rst = 0;
    tick();
    #1;
    chk("post_rst_src_ready", src_ready, 8'hFF);

    // Fill input 2 and output 5, then reset mid-cycle.
    src_data[2*NBW +: NBW] = 23'h2AAAA; src_valid = 8'h04;
    out_en = 1; addr_out = 3'd5; io_out = 23'h55555;
    tick();
    src_valid = '0; out_en = 0; addr_in = 3'd2;
    #1;
    chk("fill_src_ready", src_ready, 8'hFB);
    chk("fill_io_in",     io_in,     23'h2AAAA);
    chk("fill_snk_valid", snk_valid, 8'h20);
    chk("fill_snk_data5", snk_data[5*NBW +: NBW], 23'h55555);
    #1 rst = 1;
    #1;
    chk("midrst_src_ready", src_ready, 8'h00);
    chk("midrst_io_in",     io_in,     0);
    chk("midrst_snk_valid", snk_valid, 8'h00);
    chk("midrst_snk_data",  snk_data,  0);
    tick();
    rst = 0;
    tick();
    #1;
    chk("rel_src_ready", src_ready, 8'hFF);

    // Input round trip on channel 3.
    src_data[3*NBW +: NBW] = 23'h12345; src_valid = 8'h08;
    tick();
    src_valid = '0;
    #1;
    chk("rt_src_ready_full", src_ready, 8'hF7);
    addr_in = 3'd3;
    #1;
    chk("rt_io_in", io_in, 23'h12345);
    req_in = 1;
    tick();
    req_in = 0;
    #1;
    chk("rt_src_ready_pop", src_ready, 8'hFF);
    chk("rt_underrun",      underrun,  8'h00);

    // Underrun with a simultaneous load on empty channel 1.
    addr_in = 3'd1; req_in = 1;
    src_data[1*NBW +: NBW] = 23'h00ABC; src_valid = 8'h02;
    #1;
    chk("ur_stale_io_in", io_in, 23'h0);
    tick();
    req_in = 0; src_valid = '0;
    #1;
    chk("ur_flag",      underrun,  8'h02);
    chk("ur_src_ready", src_ready, 8'hFD);
    chk("ur_loaded",    io_in,     23'h00ABC);
    clr_flags = 1;
    tick();
    clr_flags = 0;
    #1;
    chk("ur_cleared", underrun, 8'h00);
    // Set event during clear wins.
    addr_in = 3'd6; req_in = 1; clr_flags = 1;
    tick();
    req_in = 0; clr_flags = 0;
    #1;
    chk("ur_set_wins", underrun, 8'h40);

    // Output back-to-back on channel 0 with consumer ready.
    snk_ready = 8'h01; out_en = 1; addr_out = 3'd0;
    for (int i = 1; i <= 3; i++) begin
      io_out = NBW'(i);
      tick();
      #1;
      chk("b2b_valid", snk_valid[0], 1'b1);
      chk("b2b_data",  snk_data[0 +: NBW], i);
    end
    out_en = 0;
    tick();
    #1;
    chk("b2b_drained",  snk_valid, 8'h00);
    chk("b2b_overflow", overflow,  8'h00);

    // Overflow on channel 4.
    snk_ready = 8'h00; out_en = 1; addr_out = 3'd4; io_out = 23'h7F0000;
    tick();
    io_out = 23'h000001;
    tick();
    out_en = 0;
    #1;
    chk("ov_flag",  overflow,  8'h10);
    chk("ov_data",  snk_data[4*NBW +: NBW], 23'h000001);
    chk("ov_valid", snk_valid, 8'h10);
    snk_ready = 8'h10;
    tick();
    snk_ready = 8'h00;
    #1;
    chk("ov_consumed", snk_valid, 8'h00);
    chk("ov_sticky",   overflow,  8'h10);

    // Out-of-range addresses on the six-channel instance.
    addr_in6 = 3'd7; req_in6 = 1;
    addr_out6 = 3'd6; out_en6 = 1; io_out6 = 23'h7FFFFF;
    #1;
    chk("oor_io_in", io_in6, 23'h0);
    tick();
    req_in6 = 0; out_en6 = 0;
    #1;
    chk("oor_underrun",  underrun6,  6'h00);
    chk("oor_overflow",  overflow6,  6'h00);
    chk("oor_snk_valid", snk_valid6, 6'h00);
    chk("oor_snk_data",  snk_data6,  0);
    chk("oor_src_ready", src_ready6, 6'h3F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
